// File: rtl/regfile_dbg_pkg.sv
// Shared types and constants for the register-file debug read-out engine.
package regfile_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  localparam int NUM_REGS = 16;
  localparam int PC_INDEX = 15;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register-file read port A1 over [FIRST..LAST] and streams each
// captured RD1 word on a valid/ready interface; never writes the register file.
module regfile_dump_reader
  import regfile_dbg_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int FIRST = 0,
  parameter int LAST  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(FIRST);
  localparam logic [AW-1:0] LAST_IDX  = AW'(LAST);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] index_q, index_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= FIRST_IDX;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          idx_d   = FIRST_IDX;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = FIRST_IDX;
          valid_d = 1'b0;
        end else begin
          data_d  = rf_data;
          index_d = idx_q;
          last_d  = (idx_q == LAST_IDX);
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Abort beats a same-cycle handshake: the engine simply stops.
        if (abort) begin
          state_d = IDLE;
          idx_d   = FIRST_IDX;
          valid_d = 1'b0;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = FIRST_IDX;
      end
      default: begin
        state_d = IDLE;
        idx_d   = FIRST_IDX;
        valid_d = 1'b0;
      end
    endcase
  end

  assign rf_addr   = idx_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign busy      = (state_q == READ) || (state_q == HOLD);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised self-checking bench: a full-range and a FIRST=4..LAST=7 reader share one modelled register file.
module tb_regfile_dump_reader;
  import regfile_dbg_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready, sel;
  logic [DW-1:0] rf [NUM_REGS];

  logic [AW-1:0] rf_addr0, rf_addr1, out_index0, out_index1;
  logic [DW-1:0] rf_data0, rf_data1, out_data0, out_data1;
  logic out_valid0, out_valid1, out_last0, out_last1;
  logic busy0, busy1, done0, done1;
  logic start0, start1, ready0, ready1;

  logic [AW-1:0] obs_addr, obs_index;
  logic [DW-1:0] obs_data;
  logic obs_valid, obs_last, obs_busy, obs_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  assign rf_data0 = rf[rf_addr0];
  assign rf_data1 = rf[rf_addr1];
  assign start0   = start && !sel;
  assign start1   = start && sel;
  assign ready0   = out_ready && !sel;
  assign ready1   = out_ready && sel;

  regfile_dump_reader #(.DW(DW), .AW(AW), .FIRST(0), .LAST(15)) dut (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .rf_addr(rf_addr0), .rf_data(rf_data0),
    .out_valid(out_valid0), .out_ready(ready0), .out_data(out_data0),
    .out_index(out_index0), .out_last(out_last0), .busy(busy0), .done(done0)
  );

  regfile_dump_reader #(.DW(DW), .AW(AW), .FIRST(4), .LAST(7)) dut_rng (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .rf_addr(rf_addr1), .rf_data(rf_data1),
    .out_valid(out_valid1), .out_ready(ready1), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

  always_comb begin
    obs_addr  = sel ? rf_addr1   : rf_addr0;
    obs_index = sel ? out_index1 : out_index0;
    obs_data  = sel ? out_data1  : out_data0;
    obs_valid = sel ? out_valid1 : out_valid0;
    obs_last  = sel ? out_last1  : out_last0;
    obs_busy  = sel ? busy1      : busy0;
    obs_done  = sel ? done1      : done0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
    rf[4] = 32'd255;
    rf[5] = 32'd25500;
    rf[7] = 32'd500;
  endtask

  // Expected word k is the register-file content at the moment word k is
  // first presented; writes while it is presented must not change it.
  task automatic do_dump(input int abort_at, input int stall_idx, input int snap_idx,
                         input bit rnd, input int exp_done_cyc);
    int first, last;
    logic [31:0] snap;
    bit hs, accepted;
    first = sel ? 4 : 0;
    last  = sel ? 7 : 15;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    for (int k = first; k <= last; k++) begin
      chk("read_valid", obs_valid, 0);
      chk("read_busy", obs_busy, 1);
      chk("read_done", obs_done, 0);
      tick();
      snap = rf[k];
      chk("word_index", obs_index, k);
      chk("word_data", obs_data, snap);
      chk("word_last", obs_last, (k == last));
      chk("word_valid", obs_valid, 1);
      accepted = 1'b0;
      for (int h = 0; h < 64; h++) begin
        if (k == abort_at && h == 1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          $display("abort sel=%0d at idx=%0d", sel, k);
          chk("abort_valid", obs_valid, 0);
          chk("abort_busy", obs_busy, 0);
          chk("abort_done", obs_done, 0);
          tick();
          chk("abort_nodone", obs_done, 0);
          chk("abort_addr", obs_addr, first);
          return;
        end
        if (k == abort_at) out_ready = 1'b0;
        else if (k == stall_idx) out_ready = (h >= 5);
        else if (k == snap_idx) out_ready = (h >= 2);
        else if (rnd) out_ready = ($urandom_range(0, 2) == 0);
        else out_ready = 1'b1;
        if (rnd) begin
          start = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 1) == 1) rf[$urandom_range(0, NUM_REGS - 1)] = $urandom;
        end
        if (k == snap_idx && h == 0) rf[k] = 32'd77;
        hs = out_ready;
        if (hs) $display("word sel=%0d idx=%0d data=%0d last=%0b cyc=%0d",
                         sel, obs_index, obs_data, obs_last, cyc);
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        if (hs) begin
          accepted = 1'b1;
          break;
        end
        chk("hold_valid", obs_valid, 1);
        chk("hold_data", obs_data, snap);
        chk("hold_index", obs_index, k);
        chk("hold_addr", obs_addr, k);
      end
      chk("accepted", accepted, 1);
      if (!accepted) return;
    end
    chk("done_pulse", obs_done, 1);
    chk("done_busy", obs_busy, 0);
    chk("done_valid", obs_valid, 0);
    if (exp_done_cyc > 0) chk("done_cycle", cyc, exp_done_cyc);
    $display("dump done sel=%0d cyc=%0d", sel, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_once", obs_done, 0);
    chk("done_no_restart", obs_busy, 0);
    chk("idle_addr", obs_addr, first);
    tick();
    chk("idle_busy", obs_busy, 0);
    chk("idle_valid", obs_valid, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; sel = 1'b0;
    preload();

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("rst_valid", obs_valid, 0);
    chk("rst_busy", obs_busy, 0);
    chk("rst_done", obs_done, 0);
    chk("rst_addr", obs_addr, 0);
    chk("rst_data", obs_data, 0);
    chk("rst_index", obs_index, 0);
    chk("rst_last", obs_last, 0);
    chk("rst_rng_addr", rf_addr1, 4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    $display("reset released");

    do_dump(-1, -1, -1, 1'b0, 33);   // full dump, ready held high
    do_dump(-1, 5, 7, 1'b0, 0);      // backpressure on r5, r7 overwritten while held
    chk("snap_model", rf[7], 77);
    do_dump(3, -1, -1, 1'b0, 0);     // abort on index 3
    do_dump(-1, -1, -1, 1'b0, 33);   // restart from 0, r7 now reads 77
    for (int r = 0; r < 4; r++) do_dump(-1, -1, -1, 1'b1, 0);

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    $display("start+abort in idle");
    chk("sa_busy", obs_busy, 0);
    tick();
    chk("sa_busy2", obs_busy, 0);
    chk("sa_valid", obs_valid, 0);

    // Reset in the middle of a dump.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", obs_valid, 1);
    #2 rst = 1'b1;
    #1;
    $display("reset mid-dump");
    chk("mrst_valid", obs_valid, 0);
    chk("mrst_busy", obs_busy, 0);
    chk("mrst_addr", obs_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("mrst_idle", obs_busy, 0);
    chk("mrst_idle_valid", obs_valid, 0);

    // Narrow range instance.
    sel = 1'b1;
    preload();
    do_dump(-1, -1, -1, 1'b0, 9);
    do_dump(-1, -1, -1, 1'b1, 0);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
